// File: rtl/bcd_scan_display.sv
// Binary (0..99) to two-digit BCD converter with a multiplexed 7-segment scan driver.
// Latency: done pulses 7 cycles after the edge that samples load. load is ignored while busy.
// Optional macro BCD_BLANK_LEADING_ZERO_EN blanks a zero tens digit on the display.
module bcd_scan_display #(
  parameter int REFRESH_W = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] value,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       overflow,
  output logic [6:0] seg,
  output logic [1:0] digit_en
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [6:0]           bin;
  logic [7:0]           scratch;
  logic [2:0]           shift_cnt;
  logic [7:0]           adj;
  logic [7:0]           scratch_nx;
  logic [6:0]           bin_nx;
  logic [REFRESH_W-1:0] scan_cnt;
  logic [3:0]           shown;

  // Double-dabble step: correct nibbles >= 5, then shift {scratch, bin} left by one.
  always_comb begin
    adj        = scratch;
    adj[3:0]   = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
    adj[7:4]   = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
    scratch_nx = {adj[6:0], bin[6]};
    bin_nx     = {bin[5:0], 1'b0};
  end

  // Conversion FSM with registered busy/done/result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd_tens  <= '0;
      bcd_ones  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            // Out-of-range requests saturate to 99 and flag overflow.
            bin       <= (value > 7'd99) ? 7'd99 : value;
            overflow  <= (value > 7'd99);
            scratch   <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch   <= scratch_nx;
          bin       <= bin_nx;
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd6) begin
            bcd_tens <= scratch_nx[7:4];
            bcd_ones <= scratch_nx[3:0];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running refresh counter; the active digit swaps each time it wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      digit_en <= 2'b01;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) digit_en <= {digit_en[0], digit_en[1]};
    end
  end

  // Segment decode of whichever digit is currently selected.
  always_comb begin
    shown = digit_en[1] ? bcd_tens : bcd_ones;
    case (shown)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (digit_en[1] && (bcd_tens == 4'd0)) seg = 7'h00;
`else
`endif
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  localparam int RW = 2;

  logic       clock, reset, load, busy, done, overflow;
  logic [6:0] value, seg;
  logic [3:0] bcd_tens, bcd_ones;
  logic [1:0] digit_en;

  bcd_scan_display #(.REFRESH_W(RW)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy), .done(done), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .overflow(overflow), .seg(seg), .digit_en(digit_en)
  );

  typedef struct {
    int k;
    int t;
    int o;
    int ov;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   scan_n = 0;
  int   pend_k = 0;
  bit   pend_v = 0;
  int   last_t = 0;
  int   last_o = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Edges seen since reset was last released.
  always @(posedge clock or posedge reset)
    if (reset) scan_n <= 0;
    else       scan_n <= scan_n + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int seg_of(input int d, input bit tens_sel);
    int tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (tens_sel && d == 0) return 0;
`else
    if (tens_sel && d < 0) return 0;
`endif
    return tab[d];
  endfunction

  // Monitor: pops the scoreboard on done, and checks held/display outputs every cycle.
  always @(negedge clock) begin
    exp_t e;
    bit   tens_sel;
    int   exp_busy;
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.k + 7);
        chk("bcd_tens_result", bcd_tens, e.t);
        chk("bcd_ones_result", bcd_ones, e.o);
        chk("overflow", overflow, e.ov);
        last_t = e.t;
        last_o = e.o;
      end
    end else if (q.size() != 0 && cyc > q[0].k + 7) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_done at cycle %0d: got no done, expected one at cycle %0d", cyc, e.k + 7);
    end
    exp_busy = (pend_v && cyc >= pend_k && cyc <= pend_k + 6) ? 1 : 0;
    chk("busy", busy, exp_busy);
    chk("bcd_tens_hold", bcd_tens, last_t);
    chk("bcd_ones_hold", bcd_ones, last_o);
    tens_sel = ((scan_n >> RW) % 2) == 1;
    chk("digit_en", digit_en, tens_sel ? 2 : 1);
    chk("seg", seg, seg_of(tens_sel ? last_t : last_o, tens_sel));
  end

  // Drive a one-cycle load at the current negedge; k is the sampling edge index.
  task automatic issue(input int v, input bit expect_done, output int k);
    exp_t e;
    int   c;
    value  = 7'(v);
    load   = 1'b1;
    k      = cyc + 1;
    pend_k = k;
    pend_v = 1'b1;
    if (expect_done) begin
      c    = (v > 99) ? 99 : v;
      e.k  = k;
      e.t  = c / 10;
      e.o  = c % 10;
      e.ov = (v > 99) ? 1 : 0;
      q.push_back(e);
    end
    @(negedge clock);
    load = 1'b0;
  endtask

  // Full conversion; returns at the negedge of the DONE cycle.
  task automatic run_load(input int v);
    int k;
    issue(v, 1'b1, k);
    while (cyc < k + 7) @(negedge clock);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tens", bcd_tens, 0);
    chk("rst_ones", bcd_ones, 0);
    chk("rst_digit_en", digit_en, 1);
    chk("rst_seg", seg, 'h3F);
    @(negedge clock);

    run_load(7);
    repeat (3) @(negedge clock);
    run_load(77);
    run_load(99);
    repeat (2) @(negedge clock);
    run_load(120);
    @(negedge clock);
    run_load(45);
    repeat (2) @(negedge clock);

    // A load arriving mid-conversion must not disturb it.
    issue(50, 1'b1, k);
    @(negedge clock);
    value = 7'd12;
    load  = 1'b1;
    @(negedge clock);
    load  = 1'b0;
    value = '0;
    while (cyc < k + 7) @(negedge clock);
    repeat (2) @(negedge clock);

    // Reset mid-conversion: no done may follow.
    issue(33, 1'b0, k);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    pend_v = 1'b0;
    last_t = 0;
    last_o = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_tens", bcd_tens, 0);
    chk("abort_ones", bcd_ones, 0);
    repeat (12) @(negedge clock);

    for (int i = 0; i < 20; i++) begin
      run_load(int'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (10) @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
